// File: rtl/tinyodin_ctrl_obi_responder_if.sv
// ----------------------------------------------------------------------------
// tinyodin_ctrl_obi_responder_if
// OBI bus bundle between the host interconnect and the tinyODIN control-region
// responder. Signal suffixes are named from the responder's point of view.
//   req_i    request valid             gnt_o     grant
//   we_i     write enable              rvalid_o  response valid
//   be_i     byte enables [3:0]        rdata_o   read data [31:0]
//   addr_i   byte address [31:0]
//   wdata_i  write data [31:0]
// Modports: slave (responder side), master (host side).
// ----------------------------------------------------------------------------
interface tinyodin_ctrl_obi_responder_if;
   logic        req_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/tinyodin_ctrl_obi_responder.sv
// ----------------------------------------------------------------------------
// tinyodin_ctrl_obi_responder
// OBI responder for the tinyODIN control window. Exposes CTRL, STATUS,
// TIMESTEPS, CYCLES, IRQ_EN and ID registers (word offset = addr[4:2]) and
// drives the controller's start / soft-reset / timestep inputs.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   bus            OBI slave modport (req/we/be/addr/wdata, gnt/rvalid/rdata)
//   start_o        one-cycle start pulse to the controller
//   soft_rst_o     one-cycle soft-reset pulse to the cores
//   timesteps_o    configured timestep count [TS_W-1:0]
//   busy_i         controller busy level
//   done_i         controller done pulse
//   irq_o          interrupt (only with TINYODIN_CTRL_IRQ_EN defined)
// Optional feature macro: TINYODIN_CTRL_IRQ_EN (adds IRQ_EN register + irq_o).
// ----------------------------------------------------------------------------
module tinyodin_ctrl_obi_responder #(
   parameter logic [31:0] ID_VALUE = 32'h0D100001,
   parameter int          TS_W     = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   tinyodin_ctrl_obi_responder_if.slave  bus,
   output logic                          start_o,
   output logic                          soft_rst_o,
   output logic [TS_W-1:0]               timesteps_o,
   input  logic                          busy_i,
   input  logic                          done_i
`ifdef TINYODIN_CTRL_IRQ_EN
   ,
   output logic                          irq_o
`endif
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_STATUS = 3'd1;
   localparam logic [2:0] OFF_TS     = 3'd2;
   localparam logic [2:0] OFF_CYCLES = 3'd3;
   localparam logic [2:0] OFF_IRQEN  = 3'd4;
   localparam logic [2:0] OFF_ID     = 3'd5;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Byte-enable merge of a write into the timestep field; bytes beyond TS_W
   // are dropped by the final slice.
   function automatic logic [TS_W-1:0] ts_merge(input logic [TS_W-1:0] cur,
                                                input logic [31:0]     wd,
                                                input logic [3:0]      be);
      logic [31:0] tmp;
      tmp = 32'(cur);
      for (int b = 0; b < 4; b++) begin
         if (be[b]) tmp[b*8 +: 8] = wd[b*8 +: 8];
      end
      return tmp[TS_W-1:0];
   endfunction

   logic            rvalid_q,    rvalid_d;
   logic [31:0]     rdata_q,     rdata_d;
   logic            start_q,     start_d;
   logic            srst_q,      srst_d;
   logic            done_q,      done_d;
   logic            ign_q,       ign_d;
   logic [TS_W-1:0] ts_q,        ts_d;
   logic [31:0]     cycles_q,    cycles_d;
   logic [1:0]      irq_en_q,    irq_en_d;
   logic            irq_q,       irq_d;

   logic [2:0]      off;
   logic            wr;
   logic            ctrl_wr;
   logic            start_hit;
   logic            stat_w1c;
   logic [31:0]     rd_val;
   logic            unused_addr;

   assign off         = bus.addr_i[4:2];
   assign unused_addr = ^{bus.addr_i[31:5], bus.addr_i[1:0]};

   // Never stalls: every request is granted in the same cycle.
   assign bus.gnt_o    = bus.req_i;
   // A reset arriving in the response cycle kills the pending response.
   assign bus.rvalid_o = rvalid_q & ~rst_i;
   assign bus.rdata_o  = rdata_q;
   assign start_o      = start_q;
   assign soft_rst_o   = srst_q;
   assign timesteps_o  = ts_q;

   always_comb begin
      rvalid_d  = bus.req_i;
      rdata_d   = rdata_q;
      start_d   = 1'b0;
      srst_d    = 1'b0;
      done_d    = done_q;
      ign_d     = ign_q;
      ts_d      = ts_q;
      cycles_d  = cycles_q;
      irq_en_d  = irq_en_q;
      irq_d     = 1'b0;
      rd_val    = 32'd0;

      wr        = bus.req_i & bus.we_i;
      ctrl_wr   = wr && (off == OFF_CTRL) && bus.be_i[0];
      start_hit = ctrl_wr && bus.wdata_i[0];
      stat_w1c  = wr && (off == OFF_STATUS) && bus.be_i[0];

      // Read value taken from pre-update state.
      case (off)
         OFF_STATUS: rd_val = {29'd0, ign_q, done_q, busy_i};
         OFF_TS:     rd_val = 32'(ts_q);
         OFF_CYCLES: rd_val = cycles_q;
`ifdef TINYODIN_CTRL_IRQ_EN
         OFF_IRQEN:  rd_val = {30'd0, irq_en_q};
`endif
         OFF_ID:     rd_val = ID_VALUE;
         default:    rd_val = 32'd0;
      endcase

      if (bus.req_i) rdata_d = bus.we_i ? 32'd0 : rd_val;

      start_d = start_hit && !busy_i;
      srst_d  = ctrl_wr && bus.wdata_i[1];

      // Clears first, set events last so a same-cycle set wins.
      if (srst_d || (stat_w1c && bus.wdata_i[1])) done_d = 1'b0;
      if (done_i)                                 done_d = 1'b1;
      if (srst_d || (stat_w1c && bus.wdata_i[2])) ign_d  = 1'b0;
      if (start_hit && busy_i)                    ign_d  = 1'b1;

      if (wr && (off == OFF_TS)) ts_d = ts_merge(ts_q, bus.wdata_i, bus.be_i);

      if (start_q || srst_d) cycles_d = 32'd0;
      else if (busy_i)       cycles_d = sat_inc32(cycles_q);

`ifdef TINYODIN_CTRL_IRQ_EN
      if (wr && (off == OFF_IRQEN) && bus.be_i[0]) irq_en_d = bus.wdata_i[1:0];
      irq_d = (done_q & irq_en_q[0]) | (ign_q & irq_en_q[1]);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         start_q  <= 1'b0;
         srst_q   <= 1'b0;
         done_q   <= 1'b0;
         ign_q    <= 1'b0;
         ts_q     <= '0;
         cycles_q <= 32'd0;
         irq_en_q <= 2'b00;
         irq_q    <= 1'b0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         start_q  <= start_d;
         srst_q   <= srst_d;
         done_q   <= done_d;
         ign_q    <= ign_d;
         ts_q     <= ts_d;
         cycles_q <= cycles_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

`ifdef TINYODIN_CTRL_IRQ_EN
   assign irq_o = irq_q;
`else
   logic unused_irq;
   assign unused_irq = ^{irq_q, irq_en_q};
`endif

endmodule

// File: tb/tb_tinyodin_ctrl_obi_responder.sv
module tb_tinyodin_ctrl_obi_responder;
   localparam int          TS_W = 16;
   localparam logic [31:0] ID   = 32'h0D100001;
   localparam logic [31:0] TS_MASK = 32'h0000FFFF;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_o, soft_rst_o;
   logic [TS_W-1:0] ts_o;
   logic            busy, done;
`ifdef TINYODIN_CTRL_IRQ_EN
   logic            irq_o;
`endif

   tinyodin_ctrl_obi_responder_if bus();

   tinyodin_ctrl_obi_responder #(.ID_VALUE(ID), .TS_W(TS_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .start_o     (start_o),
      .soft_rst_o  (soft_rst_o),
      .timesteps_o (ts_o),
      .busy_i      (busy),
      .done_i      (done)
`ifdef TINYODIN_CTRL_IRQ_EN
      ,
      .irq_o       (irq_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference model: register file state plus the outputs promised for the
   // current cycle.
   logic        m_rvalid, m_start, m_srst, m_done, m_ign, m_irq;
   logic [31:0] m_rdata, m_ts, m_cyc;
   logic [1:0]  m_ien;
   logic        g_busy = 1'b0, g_done = 1'b0;

   function automatic logic [31:0] model_read(input int word, input logic b);
      case (word)
         1: return {29'd0, m_ign, m_done, b};
         2: return m_ts;
         3: return m_cyc;
`ifdef TINYODIN_CTRL_IRQ_EN
         4: return {30'd0, m_ien};
`endif
         5: return ID;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_update(input logic r, input logic req, input logic we,
                               input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wd, input logic b, input logic d);
      int          word;
      logic        n_start, n_srst, n_done, n_ign, n_irq, w;
      logic [31:0] n_ts, n_cyc;
      if (r) begin
         m_rvalid = 0; m_rdata = 0; m_start = 0; m_srst = 0; m_done = 0;
         m_ign = 0; m_ts = 0; m_cyc = 0; m_ien = 0; m_irq = 0;
         return;
      end
      word = int'(addr[4:2]);
      w    = req && we;
      n_start = w && word == 0 && be[0] && wd[0] && !b;
      n_srst  = w && word == 0 && be[0] && wd[1];
      n_done  = d || (m_done && !n_srst && !(w && word == 1 && be[0] && wd[1]));
      n_ign   = (w && word == 0 && be[0] && wd[0] && b) ||
                (m_ign && !n_srst && !(w && word == 1 && be[0] && wd[2]));
      n_ts = m_ts;
      if (w && word == 2)
         for (int i = 0; i < 4; i++) if (be[i]) n_ts[i*8 +: 8] = wd[i*8 +: 8];
      n_ts &= TS_MASK;
      if (m_start || n_srst)            n_cyc = 0;
      else if (b && m_cyc != '1)        n_cyc = m_cyc + 1;
      else                              n_cyc = m_cyc;
      n_irq = (m_done && m_ien[0]) || (m_ign && m_ien[1]);
      if (req) m_rdata = we ? 32'd0 : model_read(word, b);
`ifdef TINYODIN_CTRL_IRQ_EN
      if (w && word == 4 && be[0]) m_ien = wd[1:0];
`endif
      m_rvalid = req;
      m_start = n_start; m_srst = n_srst; m_done = n_done; m_ign = n_ign;
      m_ts = n_ts; m_cyc = n_cyc; m_irq = n_irq;
   endtask

   // One clock cycle: drive just after posedge, check mid-cycle, advance model.
   task automatic step(input logic r, input logic req, input logic we,
                       input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic b, input logic d);
      rst = r; bus.req_i = req; bus.we_i = we; bus.be_i = be;
      bus.addr_i = addr; bus.wdata_i = wd; busy = b; done = d;
      #4;
      check("gnt", {31'd0, bus.gnt_o}, {31'd0, req});
      check("rvalid", {31'd0, bus.rvalid_o}, {31'd0, m_rvalid && !r});
      check("rdata", bus.rdata_o, m_rdata);
      check("start", {31'd0, start_o}, {31'd0, m_start});
      check("soft_rst", {31'd0, soft_rst_o}, {31'd0, m_srst});
      check("timesteps", 32'(ts_o), m_ts);
`ifdef TINYODIN_CTRL_IRQ_EN
      check("irq", {31'd0, irq_o}, {31'd0, m_irq});
`endif
      model_update(r, req, we, be, addr, wd, b, d);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a);
      step(0, 1, 0, 4'hF, a, $urandom, g_busy, g_done);
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      step(0, 1, 1, be, a, d, g_busy, g_done);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 32'h0, 32'h0, g_busy, g_done);
   endtask

   initial begin
      rst = 1; bus.req_i = 0; bus.we_i = 0; bus.be_i = 0; bus.addr_i = 0;
      bus.wdata_i = 0; busy = 0; done = 0;
      model_update(1, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // ID read after reset
      rd(32'h14);
      check("id_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
      check("id_value", bus.rdata_o, ID);
      idle(1);

      // TIMESTEPS byte enables
      wr(32'h08, 32'h00001234, 4'b0001);
      rd(32'h08);
      idle(1);
      wr(32'h08, 32'h00001234, 4'b0011);
      rd(32'h08);
      check("ts_be3", bus.rdata_o, 32'h00001234);
      idle(1);

      // START pulse then busy counting
      g_busy = 0;
      wr(32'h00, 32'h1, 4'hF);
      check("start_pulse", {31'd0, start_o}, 32'd1);
      idle(1);
      check("start_one_cycle", {31'd0, start_o}, 32'd0);
      g_busy = 1;
      idle(10);
      g_busy = 0;
      rd(32'h0C);
      check("cycles10", bus.rdata_o, 32'd10);

      // START ignored while busy
      g_busy = 1;
      wr(32'h00, 32'h1, 4'hF);
      check("no_start", {31'd0, start_o}, 32'd0);
      rd(32'h04);
      check("status_ign", bus.rdata_o, 32'h5);
      g_busy = 0;
      wr(32'h04, 32'h4, 4'hF);
      rd(32'h04);
      check("status_clr", bus.rdata_o, 32'h0);

      // done pulse collides with W1C: set wins
      step(0, 1, 1, 4'hF, 32'h04, 32'h2, 0, 1);
      rd(32'h04);
      check("done_set_wins", bus.rdata_o, 32'h2);
      wr(32'h04, 32'h2, 4'hF);
      rd(32'h04);
      check("done_cleared", bus.rdata_o, 32'h0);

`ifdef TINYODIN_CTRL_IRQ_EN
      wr(32'h10, 32'h1, 4'hF);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check("irq_lag0", {31'd0, irq_o}, 32'd0);
      idle(1);
      check("irq_up", {31'd0, irq_o}, 32'd1);
      wr(32'h04, 32'h2, 4'hF);
      idle(1);
      check("irq_down", {31'd0, irq_o}, 32'd0);
      wr(32'h10, 32'h0, 4'hF);
`endif

      // soft reset clears sticky state, pulse lasts one cycle
      g_busy = 1;
      wr(32'h00, 32'h1, 4'hF);
      g_busy = 0;
      wr(32'h00, 32'h2, 4'hF);
      check("srst_pulse", {31'd0, soft_rst_o}, 32'd1);
      rd(32'h04);
      check("srst_one_cycle", {31'd0, soft_rst_o}, 32'd0);
      check("srst_status", bus.rdata_o, 32'h0);

      // back-to-back accepts, reset kills the last response
      rd(32'h14);
      check("b2b_0", bus.rdata_o, ID);
      wr(32'h08, 32'h0000ABCD, 4'hF);
      check("b2b_1", bus.rdata_o, 32'h0);
      rd(32'h08);
      check("b2b_2", bus.rdata_o, 32'h0000ABCD);
      rd(32'hFFFF_FF1C);
      check("b2b_3v", {31'd0, bus.rvalid_o}, 32'd1);
      rst = 1;
      #1;
      check("rst_suppress", {31'd0, bus.rvalid_o}, 32'd0);
      #0;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic        r, q, w;
         logic [31:0] a, d;
         r = ($urandom_range(0, 199) == 0);
         q = ($urandom_range(0, 9) < 7);
         w = $urandom_range(0, 1);
         a = $urandom;
         d = $urandom;
         if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
         if ($urandom_range(0, 7) == 0) g_busy = ~g_busy;
         g_done = ($urandom_range(0, 9) == 0);
         step(r, q, w, 4'($urandom), a, d, g_busy, g_done);
      end
      g_done = 0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
